// File: rtl/pipe_run_pkg.sv
// Shared types and default sizing for the pipeline run controller slice.
package pipe_run_pkg;

  localparam int WORD_SIZE_D = 32;
  localparam int ADDR_LEN_D  = 5;
  localparam int MEM_SIZE_D  = 32;
  localparam int INST_LEN_D  = 17;
  localparam int INST_CAP_D  = 5;
  localparam int CYCLE_W_D   = 16;

  localparam logic LD_SEL_DMEM = 1'b0;
  localparam logic LD_SEL_IMEM = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DUMP_RD,
    ST_DUMP_OUT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/pipe_run_ctrl_dump.sv
// Data memory dump streamer: walks addresses 0..MEM_SIZE-1 and presents each
// word on a valid/ready port, reporting advance/finished back to the parent FSM.
module mem_dump_streamer #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_LEN  = 5,
  parameter int MEM_SIZE  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 out_i,
  input  logic [WORD_SIZE-1:0] dmem_rdata_i,
  output logic [ADDR_LEN-1:0]  rd_addr_o,
  output logic                 dump_valid_o,
  input  logic                 dump_ready_i,
  output logic [ADDR_LEN-1:0]  dump_addr_o,
  output logic [WORD_SIZE-1:0] dump_data_o,
  output logic                 dump_last_o,
  output logic                 advance_o,
  output logic                 finished_o
);

  localparam logic [ADDR_LEN-1:0] LAST_ADDR = ADDR_LEN'(MEM_SIZE - 1);

  logic [ADDR_LEN-1:0]  ptr_q, ptr_d;
  logic [WORD_SIZE-1:0] data_q;
  logic                 held_q;
  logic                 hs, is_last;

  assign hs      = out_i && dump_ready_i;
  assign is_last = (ptr_q == LAST_ADDR);

  always_comb begin
    ptr_d = ptr_q;
    if (start_i)
      ptr_d = '0;
    else if (hs && !is_last)
      ptr_d = ptr_q + 1'b1;
  end

  // Read data arrives in the first output cycle; it is shown directly then and
  // held in data_q for any further stall cycles, keeping a 2-cycle word rate.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      data_q <= '0;
      held_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      held_q <= out_i && !hs;
      if (out_i && !held_q)
        data_q <= dmem_rdata_i;
    end
  end

  assign rd_addr_o    = ptr_q;
  assign dump_valid_o = out_i;
  assign dump_addr_o  = out_i ? ptr_q : '0;
  assign dump_data_o  = !out_i ? '0 : (held_q ? data_q : dmem_rdata_i);
  assign dump_last_o  = out_i && is_last;
  assign advance_o    = hs && !is_last;
  assign finished_o   = hs && is_last;

endmodule

// File: rtl/pipe_run_ctrl.sv
// Run controller: loads imem/dmem with the core held in reset, runs the core for
// a cycle budget or until halt, then streams all of data memory out.
module pipe_run_ctrl
  import pipe_run_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_D,
  parameter int ADDR_LEN  = ADDR_LEN_D,
  parameter int MEM_SIZE  = MEM_SIZE_D,
  parameter int INST_LEN  = INST_LEN_D,
  parameter int INST_CAP  = INST_CAP_D,
  parameter int CYCLE_W   = CYCLE_W_D
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CYCLE_W-1:0]   run_cycles,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic                 ld_sel,
  input  logic [ADDR_LEN-1:0]  ld_addr,
  input  logic [WORD_SIZE-1:0] ld_data,
  input  logic                 ld_last,
  output logic                 ld_err,
  output logic                 core_rstn,
  input  logic                 core_halt,
  output logic                 dmem_we,
  output logic [ADDR_LEN-1:0]  dmem_addr,
  output logic [WORD_SIZE-1:0] dmem_wdata,
  input  logic [WORD_SIZE-1:0] dmem_rdata,
  output logic                 imem_we,
  output logic [ADDR_LEN-1:0]  imem_addr,
  output logic [INST_LEN-1:0]  imem_wdata,
  output logic                 dump_valid,
  input  logic                 dump_ready,
  output logic [ADDR_LEN-1:0]  dump_addr,
  output logic [WORD_SIZE-1:0] dump_data,
  output logic                 dump_last,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [CYCLE_W-1:0]   cycles_run
);

  state_e               state_q, state_d;
  logic [CYCLE_W-1:0]   budget_q, budget_d;
  logic [CYCLE_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [CYCLE_W-1:0]   cycles_run_q, cycles_run_d;
  logic                 timeout_q, timeout_d;
  logic                 ld_err_q, ld_err_d;
  logic                 ld_hs, addr_ok, dump_start;
  logic [ADDR_LEN-1:0]  rd_addr;
  logic                 advance, finished;

  always_comb begin
    state_d      = state_q;
    budget_d     = budget_q;
    cnt_d        = cnt_q;
    cycles_run_d = cycles_run_q;
    timeout_d    = timeout_q;
    ld_err_d     = ld_err_q;
    cnt_inc      = cnt_q + 1'b1;
    ld_ready     = 1'b0;
    ld_hs        = 1'b0;
    addr_ok      = 1'b0;
    core_rstn    = 1'b0;
    dmem_we      = 1'b0;
    imem_we      = 1'b0;
    dmem_addr    = '0;
    dmem_wdata   = '0;
    imem_addr    = '0;
    imem_wdata   = '0;
    dump_start   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_LOAD;
          budget_d     = run_cycles;
          timeout_d    = 1'b0;
          ld_err_d     = 1'b0;
          cycles_run_d = '0;
        end
      end
      ST_LOAD: begin
        // ld_ready drops in the reset cycle so no write can slip out.
        ld_ready   = !rst;
        ld_hs      = ld_valid && !rst;
        dmem_addr  = ld_addr;
        dmem_wdata = ld_data;
        imem_addr  = ld_addr;
        imem_wdata = ld_data[INST_LEN-1:0];
        addr_ok    = (ld_sel == LD_SEL_IMEM) ? (int'(ld_addr) < INST_CAP)
                                             : (int'(ld_addr) < MEM_SIZE);
        if (ld_hs) begin
          if (addr_ok) begin
            dmem_we = (ld_sel == LD_SEL_DMEM);
            imem_we = (ld_sel == LD_SEL_IMEM);
          end else begin
            ld_err_d = 1'b1;
          end
          if (ld_last) begin
            cnt_d = '0;
            if (budget_q == '0) begin
              state_d      = ST_DUMP_RD;
              timeout_d    = 1'b1;
              cycles_run_d = '0;
              dump_start   = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
      end
      ST_RUN: begin
        core_rstn = 1'b1;
        cnt_d     = cnt_inc;
        if (core_halt || (cnt_inc == budget_q)) begin
          state_d      = ST_DUMP_RD;
          timeout_d    = !core_halt;
          cycles_run_d = cnt_inc;
          dump_start   = 1'b1;
        end
      end
      ST_DUMP_RD: begin
        dmem_addr = rd_addr;
        state_d   = ST_DUMP_OUT;
      end
      ST_DUMP_OUT: begin
        dmem_addr = rd_addr;
        if (finished)
          state_d = ST_DONE;
        else if (advance)
          state_d = ST_DUMP_RD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      budget_q     <= '0;
      cnt_q        <= '0;
      cycles_run_q <= '0;
      timeout_q    <= 1'b0;
      ld_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      budget_q     <= budget_d;
      cnt_q        <= cnt_d;
      cycles_run_q <= cycles_run_d;
      timeout_q    <= timeout_d;
      ld_err_q     <= ld_err_d;
    end
  end

  mem_dump_streamer #(
    .WORD_SIZE (WORD_SIZE),
    .ADDR_LEN  (ADDR_LEN),
    .MEM_SIZE  (MEM_SIZE)
  ) u_dump (
    .clk          (clk),
    .rst          (rst),
    .start_i      (dump_start),
    .out_i        (state_q == ST_DUMP_OUT),
    .dmem_rdata_i (dmem_rdata),
    .rd_addr_o    (rd_addr),
    .dump_valid_o (dump_valid),
    .dump_ready_i (dump_ready),
    .dump_addr_o  (dump_addr),
    .dump_data_o  (dump_data),
    .dump_last_o  (dump_last),
    .advance_o    (advance),
    .finished_o   (finished)
  );

  assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done       = (state_q == ST_DONE);
  assign timeout    = timeout_q;
  assign ld_err     = ld_err_q;
  assign cycles_run = cycles_run_q;

endmodule
